// File: rtl/oversample_dru.sv
`default_nettype none
// ============================================================================
// Module   : oversample_dru
// Purpose  : Oversampled data recovery unit. Finds the edge phase of an
//            oversampled serial line and picks the sample opposite the edge
//            (half a bit away). Data bits are emitted one window per cycle.
//            When the sampling phase wraps, one bit is dropped or one is
//            added.
// Ports    : clk           - clock
//            aresetn       - asynchronous active-low reset
//            sample_valid  - sample_window is valid this cycle
//            sample_window - SAMPLES samples, bit 0 earliest
//            data_out      - recovered bits, bit 0 earliest (lowest
//                            data_count bits meaningful)
//            data_count    - BITS-1, BITS or BITS+1 valid bits
//            data_valid    - data_out/data_count valid
//            phase         - current sampling phase
//            locked        - set by the first confirmed phase decision
//            slip_count    - saturating count of phase wraps
// Options  : define OVERSAMPLE_DRU_STATS_EN to build the slip counter;
//            otherwise slip_count is tied to zero.
// Latency  : a window accepted in cycle c appears on the outputs in cycle c+2
//            (two register stages).
// Revision : 1.0 - initial release
// ============================================================================
module oversample_dru #(
  parameter  int SAMPLES    = 8,
  parameter  int RATIO      = 4,
  parameter  int PHASE_HOLD = 4,
  localparam int BITS       = SAMPLES / RATIO,
  localparam int CW         = $clog2(BITS + 2),
  localparam int PW         = $clog2(RATIO)
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               sample_valid,
  input  logic [SAMPLES-1:0] sample_window,
  output logic [BITS:0]      data_out,
  output logic [CW-1:0]      data_count,
  output logic               data_valid,
  output logic [PW-1:0]      phase,
  output logic               locked,
  output logic [15:0]        slip_count
);

  localparam int HW = $clog2(PHASE_HOLD + 1);
  localparam int SW = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

  localparam logic [1:0] c_MODE_NORMAL = 2'd0;
  localparam logic [1:0] c_MODE_FWD    = 2'd1;  // RATIO-1 -> 0: one bit fewer
  localparam logic [1:0] c_MODE_BWD    = 2'd2;  // 0 -> RATIO-1: one bit more

  // Phase tracking state
  logic [PW-1:0] r_phase;
  logic [PW-1:0] r_prev_phase;   // phase used by the previous accepted window
  logic [PW-1:0] r_cand;
  logic [HW-1:0] r_hold;
  logic          r_locked;
  logic          r_msb;          // MSB of the previous accepted window

  // Stage 1 registers
  logic               r_s1_valid;
  logic [SAMPLES-1:0] r_s1_win;
  logic               r_s1_prev_msb;
  logic [PW-1:0]      r_s1_phase;
  logic [1:0]         r_s1_mode;

  // Stage 2 (output) registers
  logic [BITS:0]   r_data_out;
  logic [CW-1:0]   r_data_count;
  logic            r_data_valid;

  // Edge detection
  logic [SAMPLES-1:0]             w_trans;
  logic [RATIO-1:0][BITS-1:0]     w_edge_terms;
  logic [RATIO-1:0]               w_edge;
  logic                           w_single;
  logic [PW-1:0]                  w_cand_p;
  logic [HW-1:0]                  w_hold_next;
  logic                           w_decide;
  logic [PW-1:0]                  w_new_phase;
  logic [1:0]                     w_mode;

  // Extraction
  logic [BITS:0]   w_dout;
  logic [CW-1:0]   w_dcnt;
  logic [SW-1:0]   w_idx;

  // Sample i is compared with sample i-1; sample 0 with the last window's MSB.
  assign w_trans = sample_window ^ {sample_window[SAMPLES-2:0], r_msb};

  for (genvar p = 0; p < RATIO; p++) begin : g_phase
    for (genvar k = 0; k < BITS; k++) begin : g_slot
      assign w_edge_terms[p][k] = w_trans[k*RATIO+p];
    end
    assign w_edge[p] = |w_edge_terms[p];
  end

  assign w_single = $onehot(w_edge);

  always_comb begin
    w_cand_p = '0;
    for (int p = 0; p < RATIO; p++) begin
      if (w_edge[p]) w_cand_p = PW'(p);
    end
  end

  assign w_hold_next = (w_cand_p == r_cand) ? r_hold + HW'(1) : HW'(1);
  assign w_decide    = w_single && (w_hold_next == HW'(PHASE_HOLD));
  // RATIO is a power of two, so the PW-bit add wraps modulo RATIO.
  assign w_new_phase = w_cand_p + PW'(RATIO / 2);

  // Classify the phase change between the previous window and this one.
  always_comb begin
    w_mode = c_MODE_NORMAL;
    if (r_prev_phase == PW'(RATIO - 1) && r_phase == '0)
      w_mode = c_MODE_FWD;
    else if (r_prev_phase == '0 && r_phase == PW'(RATIO - 1))
      w_mode = c_MODE_BWD;
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_phase      <= PW'(RATIO / 2);
      r_prev_phase <= PW'(RATIO / 2);
      r_cand       <= '0;
      r_hold       <= '0;
      r_locked     <= 1'b0;
      r_msb        <= 1'b0;
    end else if (sample_valid) begin
      r_msb        <= sample_window[SAMPLES-1];
      r_prev_phase <= r_phase;
      if (w_single) begin
        r_cand <= w_cand_p;
        if (w_decide) begin
          r_phase  <= w_new_phase;
          r_hold   <= '0;
          r_locked <= 1'b1;
        end else begin
          r_hold <= w_hold_next;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_s1_valid    <= 1'b0;
      r_s1_win      <= '0;
      r_s1_prev_msb <= 1'b0;
      r_s1_phase    <= PW'(RATIO / 2);
      r_s1_mode     <= c_MODE_NORMAL;
    end else begin
      r_s1_valid <= sample_valid;
      if (sample_valid) begin
        r_s1_win      <= sample_window;
        r_s1_prev_msb <= r_msb;
        r_s1_phase    <= r_phase;
        r_s1_mode     <= w_mode;
      end
    end
  end

  always_comb begin
    w_dout = '0;
    w_dcnt = CW'(BITS);
    w_idx  = '0;
    case (r_s1_mode)
      c_MODE_FWD: begin
        // Phase is 0 here; slot 0 was already covered by the last window.
        w_dcnt = CW'(BITS - 1);
        for (int k = 0; k < BITS - 1; k++) begin
          w_dout[k] = r_s1_win[(k+1)*RATIO];
        end
      end
      c_MODE_BWD: begin
        // Phase is RATIO-1 here; the previous window's MSB is an extra bit.
        w_dcnt    = CW'(BITS + 1);
        w_dout[0] = r_s1_prev_msb;
        for (int k = 0; k < BITS; k++) begin
          w_dout[k+1] = r_s1_win[k*RATIO+RATIO-1];
        end
      end
      default: begin
        for (int k = 0; k < BITS; k++) begin
          w_idx     = SW'(k * RATIO) + SW'(r_s1_phase);
          w_dout[k] = r_s1_win[w_idx];
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_data_valid <= 1'b0;
      r_data_out   <= '0;
      r_data_count <= '0;
    end else begin
      r_data_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_data_out   <= w_dout;
        r_data_count <= w_dcnt;
      end
    end
  end

`ifdef OVERSAMPLE_DRU_STATS_EN
  logic [15:0] r_slip;

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_slip <= '0;
    end else if (r_s1_valid && r_s1_mode != c_MODE_NORMAL && r_slip != 16'hFFFF) begin
      r_slip <= r_slip + 16'd1;
    end
  end

  assign slip_count = r_slip;
`else
  assign slip_count = 16'd0;
`endif

  assign data_out   = r_data_out;
  assign data_count = r_data_count;
  assign data_valid = r_data_valid;
  assign phase      = r_phase;
  assign locked     = r_locked;

endmodule
`default_nettype wire

// File: tb/tb_oversample_dru.sv
`default_nettype none
// ============================================================================
// Module   : tb_oversample_dru
// Purpose  : Directed self-checking bench for oversample_dru with
//            SAMPLES=8, RATIO=4, PHASE_HOLD=4. Expected outputs per window
//            are hand-computed and queued; a monitor matches every
//            data_valid against the queue, including latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_oversample_dru;

  localparam int SAMPLES    = 8;
  localparam int RATIO      = 4;
  localparam int PHASE_HOLD = 4;

`ifdef OVERSAMPLE_DRU_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        aresetn;
  logic        sample_valid;
  logic [7:0]  sample_window;
  logic [2:0]  data_out;
  logic [1:0]  data_count;
  logic        data_valid;
  logic [1:0]  phase;
  logic        locked;
  logic [15:0] slip_count;

  always #5 clk = ~clk;

  oversample_dru #(
    .SAMPLES   (SAMPLES),
    .RATIO     (RATIO),
    .PHASE_HOLD(PHASE_HOLD)
  ) u_dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .sample_valid (sample_valid),
    .sample_window(sample_window),
    .data_out     (data_out),
    .data_count   (data_count),
    .data_valid   (data_valid),
    .phase        (phase),
    .locked       (locked),
    .slip_count   (slip_count)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [2:0] dout;
    logic [1:0] cnt;
    int         acc;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: every data_valid must match the oldest queued window,
  // one edge after the edge that accepted it.
  always @(negedge clk) begin
    if (aresetn === 1'b1 && data_valid === 1'b1) begin
      if (q.size() == 0) begin
        check("unexpected_valid", 32'(data_valid), 32'd0);
      end else begin
        exp_t        e;
        logic [31:0] m;
        e = q.pop_front();
        m = (32'd1 << e.cnt) - 32'd1;
        check({e.tag, "_dout"}, 32'(data_out) & m, 32'(e.dout) & m);
        check({e.tag, "_cnt"},  32'(data_count),   32'(e.cnt));
        check({e.tag, "_lat"},  32'(cyc - e.acc),  32'd1);
      end
    end
  end

  task automatic drive(input logic [7:0] w, input logic [2:0] dout,
                       input logic [1:0] cnt, input string tag);
    exp_t e;
    @(negedge clk);
    sample_valid  = 1'b1;
    sample_window = w;
    @(posedge clk);
    #1;
    e.dout = dout;
    e.cnt  = cnt;
    e.acc  = cyc;
    e.tag  = tag;
    q.push_back(e);
  endtask

  task automatic idle(input int n, input logic [7:0] w);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sample_valid  = 1'b0;
      sample_window = w;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    aresetn       = 1'b0;
    sample_valid  = 1'b0;
    sample_window = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_phase",  32'(phase),      32'd2);
    check("rst_locked", 32'(locked),     32'd0);
    check("rst_valid",  32'(data_valid), 32'd0);
    check("rst_slip",   32'(slip_count), 32'd0);
    check("rst_count",  32'(data_count), 32'd0);
    check("rst_dout",   32'(data_out),   32'd0);
    @(negedge clk);
    aresetn = 1'b1;

    // Steady F0: edge phase 0, sample at phase 2 -> {s6,s2} = 2'b10
    for (int i = 0; i < 3; i++) drive(8'hF0, 3'b010, 2'd2, "steady");
    check("steady_unlocked", 32'(locked), 32'd0);
    drive(8'hF0, 3'b010, 2'd2, "steady");
    check("steady_locked", 32'(locked), 32'd1);
    check("steady_phase",  32'(phase),  32'd2);

    // Hysteresis: three phase-1 windows interrupted by a phase-0 window
    for (int i = 0; i < 3; i++) drive(8'hE1, 3'b010, 2'd2, "hyst_a");
    idle(1, 8'h00);
    check("idle_phase", 32'(phase), 32'd2);
    drive(8'hF0, 3'b010, 2'd2, "hyst_brk");
    check("hyst_hold", 32'(phase), 32'd2);
    for (int i = 0; i < 3; i++) drive(8'hE1, 3'b010, 2'd2, "hyst_b");
    check("hyst_3of4", 32'(phase), 32'd2);
    drive(8'hE1, 3'b010, 2'd2, "hyst_b");
    check("hyst_move", 32'(phase), 32'd3);

    // Forward wrap 3 -> 0: edge phase 2 held; phase 3 picks {s7,s3} = 2'b10
    for (int i = 0; i < 4; i++) drive(8'hC3, 3'b010, 2'd2, "fwd_pre");
    check("fwd_phase", 32'(phase), 32'd0);
    drive(8'hC3, 3'b000, 2'd1, "fwd_wrap");   // only s4 = 0 survives
    idle(2, 8'h00);
    check("fwd_slip", 32'(slip_count), 32'(STATS));

    // Backward wrap 0 -> 3: edge phase 1 held; phase 0 picks {s4,s0} = 2'b01
    for (int i = 0; i < 4; i++) drive(8'hE1, 3'b001, 2'd2, "bwd_pre");
    check("bwd_phase", 32'(phase), 32'd3);
    // {s7, s3, previous MSB} = {1, 0, 1}
    drive(8'hF0, 3'b101, 2'd3, "bwd_wrap");
    idle(2, 8'h00);
    check("bwd_slip", 32'(slip_count), 32'(2 * STATS));

    // Noise: edges at phases 0 and 2 leave counter (1, cand 0) untouched
    for (int i = 0; i < 2; i++) drive(8'hF3, 3'b010, 2'd2, "noise");
    check("noise_phase", 32'(phase), 32'd3);
    for (int i = 0; i < 2; i++) drive(8'hF0, 3'b010, 2'd2, "post_noise");
    check("noise_cnt_kept", 32'(phase), 32'd3);
    drive(8'hF0, 3'b010, 2'd2, "post_noise");
    check("noise_decide", 32'(phase), 32'd2);
    drive(8'hF0, 3'b010, 2'd2, "step_3to2");
    for (int i = 0; i < 4; i++) drive(8'hE1, 3'b010, 2'd2, "pre_rst");
    check("pre_rst_phase", 32'(phase), 32'd3);

    // Reset with two windows in flight
    @(negedge clk);
    sample_valid  = 1'b1;
    sample_window = 8'hF0;
    @(posedge clk);
    @(negedge clk);
    sample_window = 8'h0F;
    #1;
    aresetn = 1'b0;
    #1;
    check("mid_rst_phase",  32'(phase),      32'd2);
    check("mid_rst_locked", 32'(locked),     32'd0);
    check("mid_rst_valid",  32'(data_valid), 32'd0);
    check("mid_rst_slip",   32'(slip_count), 32'd0);
    check("mid_rst_count",  32'(data_count), 32'd0);
    check("mid_rst_dout",   32'(data_out),   32'd0);
    sample_valid = 1'b0;
    repeat (2) @(negedge clk);
    aresetn = 1'b1;
    idle(2, 8'hFF);
    check("post_rst_valid", 32'(data_valid), 32'd0);
    drive(8'hF0, 3'b010, 2'd2, "post_rst");
    idle(3, 8'h00);
    check("post_rst_locked", 32'(locked), 32'd0);
    check("post_rst_phase",  32'(phase),  32'd2);
    check("drain", 32'(q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
